// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// The PC register fetches sequentially from a combinational instruction memory
// into a small FIFO of {pc, inst} pairs. Decode drains the FIFO through a
// valid/ready handshake. A one-cycle redirect pulse reloads the PC and flushes
// the FIFO.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter int              IMEM_AW  = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [IMEM_AW-1:0]       imem_addr,
   input  logic [XLEN-1:0]          imem_data,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_inst,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_pc_plus4,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     misalign_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [XLEN-1:0] pc_reg, pc_next;
   logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0]   count_reg, count_next;
   logic            err_reg, err_next;

   logic [XLEN-1:0] fifo_pc_reg   [DEPTH];
   logic [XLEN-1:0] fifo_inst_reg [DEPTH];

   logic            head_valid;
   logic            push;
   logic            pop;

   // Fetch address comes straight from the PC register only.
   assign imem_addr = pc_reg[IMEM_AW+1:2];

   // Head is hidden while a redirect squashes the queue, and while in reset.
   assign head_valid = (count_reg != '0) & ~redirect_valid & ~rst;
   assign pop        = head_valid & out_ready;
   assign push       = ~redirect_valid & ((count_reg < FULL) | pop);

   // Output view: zeros whenever no valid head is presented.
   always_comb begin
      out_valid    = head_valid;
      out_inst     = '0;
      out_pc       = '0;
      out_pc_plus4 = '0;
      if (head_valid) begin
         out_inst     = fifo_inst_reg[rd_ptr_reg];
         out_pc       = fifo_pc_reg[rd_ptr_reg];
         out_pc_plus4 = fifo_pc_reg[rd_ptr_reg] + XLEN'(4);
      end
      count        = rst ? '0 : count_reg;
      misalign_err = rst ? 1'b0 : err_reg;
   end

   // Next-state logic: redirect flushes and reloads, otherwise push/pop.
   always_comb begin
      pc_next     = pc_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg + CW'(push) - CW'(pop);
      err_next    = err_reg;
      if (redirect_valid) begin
         pc_next     = {redirect_pc[XLEN-1:2], 2'b00};
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
         if (redirect_pc[1:0] != 2'b00) begin
            err_next = 1'b1;
         end
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
            pc_next     = pc_reg + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
         end
      end
   end

   // Control state register; reset wins over redirect and push.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg     <= RESET_PC;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         err_reg    <= 1'b0;
      end else begin
         pc_reg     <= pc_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
         err_reg    <= err_next;
      end
   end

   // FIFO storage: capture the current fetch on every push.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         fifo_pc_reg[wr_ptr_reg]   <= pc_reg;
         fifo_inst_reg[wr_ptr_reg] <= imem_data;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a per-cycle vector table covering fetch,
// back-pressure, flush, misaligned redirect and mid-run reset, plus a
// hand-written sequence for PC wrap-around on a second instance.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;

   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic [31:0] out_inst, out_pc, out_pc_plus4;
   logic [2:0]  count;
   logic        misalign_err;

   logic        w_rst;
   logic [7:0]  w_imem_addr;
   logic [31:0] w_imem_data;
   logic        w_out_valid;
   logic [31:0] w_out_inst, w_out_pc, w_out_pc_plus4;
   logic [2:0]  w_count;
   logic        w_misalign_err;

   logic [31:0] imem [256];

   int pass_cnt  = 0;
   int check_cnt = 0;

   always #5 clk = ~clk;

   assign imem_data   = imem[imem_addr];
   assign w_imem_data = imem[w_imem_addr];

   fetch_queue u_dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .count(count),
      .misalign_err(misalign_err)
   );

   fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(w_rst), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .out_valid(w_out_valid), .out_ready(1'b1), .out_inst(w_out_inst),
      .out_pc(w_out_pc), .out_pc_plus4(w_out_pc_plus4), .count(w_count),
      .misalign_err(w_misalign_err)
   );

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [2:0]  e_cnt;
      logic [7:0]  e_addr;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [2:0] cnt, input logic [7:0] addr, input logic err);
      vec_t t;
      t.rst = r; t.rdy = rdy; t.rv = rv; t.rpc = rpc;
      t.e_valid = v; t.e_pc = pc; t.e_inst = inst; t.e_cnt = cnt;
      t.e_addr = addr; t.e_err = err;
      vecs.push_back(t);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 32'h100 + i;

      // --- fetch after reset release, ready held high
      add(0,1,0,0,      0,32'h00,32'h000,0,8'd0,0);
      add(0,1,0,0,      1,32'h00,32'h100,1,8'd1,0);
      add(0,1,0,0,      1,32'h04,32'h101,1,8'd2,0);
      add(0,1,0,0,      1,32'h08,32'h102,1,8'd3,0);
      // --- mid-run reset
      add(1,1,0,0,      0,32'h00,32'h000,0,8'd4,0);
      // --- back-pressure: 10 cycles not ready, queue fills, pc holds at 16
      add(0,0,0,0,      0,32'h00,32'h000,0,8'd0,0);
      add(0,0,0,0,      1,32'h00,32'h100,1,8'd1,0);
      add(0,0,0,0,      1,32'h00,32'h100,2,8'd2,0);
      add(0,0,0,0,      1,32'h00,32'h100,3,8'd3,0);
      for (int k = 0; k < 6; k++)
         add(0,0,0,0,   1,32'h00,32'h100,4,8'd4,0);
      // --- drain in order, pc=16 follows without a gap
      add(0,1,0,0,      1,32'h00,32'h100,4,8'd4,0);
      add(0,1,0,0,      1,32'h04,32'h101,4,8'd5,0);
      add(0,1,0,0,      1,32'h08,32'h102,4,8'd6,0);
      add(0,1,0,0,      1,32'h0C,32'h103,4,8'd7,0);
      add(0,1,0,0,      1,32'h10,32'h104,4,8'd8,0);
      // --- redirect from a full queue to 0x40
      add(0,1,1,32'h40, 0,32'h00,32'h000,4,8'd9,0);
      add(0,1,0,0,      0,32'h00,32'h000,0,8'd16,0);
      add(0,1,0,0,      1,32'h40,32'h110,1,8'd17,0);
      // --- build count=3, then redirect while ready (misaligned 0x42)
      add(0,0,0,0,      1,32'h44,32'h111,1,8'd18,0);
      add(0,0,0,0,      1,32'h44,32'h111,2,8'd19,0);
      add(0,1,1,32'h42, 0,32'h00,32'h000,3,8'd20,0);
      add(0,1,0,0,      0,32'h00,32'h000,0,8'd16,1);
      add(0,1,0,0,      1,32'h40,32'h110,1,8'd17,1);
      // --- back-to-back redirects, the last one wins; error stays sticky
      add(0,1,1,32'h80, 0,32'h00,32'h000,1,8'd18,1);
      add(0,1,1,32'h20, 0,32'h00,32'h000,0,8'd32,1);
      add(0,1,0,0,      0,32'h00,32'h000,0,8'd8,1);
      add(0,1,0,0,      1,32'h20,32'h108,1,8'd9,1);
      // --- reset overrides a simultaneous redirect and clears the error
      add(1,1,1,32'h80, 0,32'h00,32'h000,0,8'd10,0);
      add(0,1,0,0,      0,32'h00,32'h000,0,8'd0,0);
      add(0,1,0,0,      1,32'h00,32'h100,1,8'd1,0);

      // initial reset of both instances
      rst = 1'b1; w_rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset count", 32'(count), 32'h0);
      chk("reset out_pc", out_pc, 32'h0);
      chk("reset imem_addr", 32'(imem_addr), 32'h0);
      chk("reset misalign_err", 32'(misalign_err), 32'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         rst            = vecs[i].rst;
         out_ready      = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         #1;
         chk($sformatf("r%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
         chk($sformatf("r%0d out_pc", i), out_pc, vecs[i].e_pc);
         chk($sformatf("r%0d out_inst", i), out_inst, vecs[i].e_inst);
         chk($sformatf("r%0d out_pc_plus4", i), out_pc_plus4,
             vecs[i].e_valid ? vecs[i].e_pc + 32'd4 : 32'h0);
         chk($sformatf("r%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
         chk($sformatf("r%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
         chk($sformatf("r%0d misalign_err", i), 32'(misalign_err), 32'(vecs[i].e_err));
         $display("row %0d: rst=%0b rdy=%0b rv=%0b rpc=%h -> valid=%0b pc=%h inst=%h cnt=%0d addr=%h err=%0b",
                  i, vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc,
                  out_valid, out_pc, out_inst, count, imem_addr, misalign_err);
         @(posedge clk); #1;
      end
      rst = 1'b0; redirect_valid = 1'b0;

      // --- PC wrap-around from RESET_PC=0xFFFFFFF8
      w_rst = 1'b0;
      #1;
      chk("wrap c0 out_valid", 32'(w_out_valid), 32'h0);
      chk("wrap c0 imem_addr", 32'(w_imem_addr), 32'hFE);
      chk("wrap c0 count", 32'(w_count), 32'h0);
      @(posedge clk); #1;
      chk("wrap c1 out_valid", 32'(w_out_valid), 32'h1);
      chk("wrap c1 out_pc", w_out_pc, 32'hFFFF_FFF8);
      chk("wrap c1 out_inst", w_out_inst, 32'h1FE);
      chk("wrap c1 imem_addr", 32'(w_imem_addr), 32'hFF);
      $display("wrap c1: pc=%h inst=%h addr=%h", w_out_pc, w_out_inst, w_imem_addr);
      @(posedge clk); #1;
      chk("wrap c2 out_pc", w_out_pc, 32'hFFFF_FFFC);
      chk("wrap c2 out_inst", w_out_inst, 32'h1FF);
      chk("wrap c2 out_pc_plus4", w_out_pc_plus4, 32'h0);
      chk("wrap c2 imem_addr", 32'(w_imem_addr), 32'h00);
      $display("wrap c2: pc=%h inst=%h addr=%h", w_out_pc, w_out_inst, w_imem_addr);
      @(posedge clk); #1;
      chk("wrap c3 out_pc", w_out_pc, 32'h0);
      chk("wrap c3 out_inst", w_out_inst, 32'h100);
      chk("wrap c3 imem_addr", 32'(w_imem_addr), 32'h01);
      chk("wrap c3 misalign_err", 32'(w_misalign_err), 32'h0);
      $display("wrap c3: pc=%h inst=%h addr=%h", w_out_pc, w_out_inst, w_imem_addr);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
